mux_canais_registrado: RTL and testbench

- Parametrised N-way, WIDTH-bit selector with a registered output and a valid/ready handshake.
- Feeds datapath operand and writeback selection where the consumer may stall.
- Two modes:
  - Direct: channel chosen by `seletor`.
  - Round-robin scan: channel chosen by an internal pointer.
- Out-of-range selections are trapped and flagged, never forwarded.

---
 rtl/mux_canais_registrado_if.sv | 28 ++
 rtl/mux_canais_registrado.sv | 87 ++++++++
 tb/tb_mux_canais_registrado.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/mux_canais_registrado_if.sv
// Request/result bundle of the registered channel selector; master is the
// side that offers channels and consumes results, slave is the selector itself.
interface mux_canais_registrado_if #(
    parameter int WIDTH      = 32,
    parameter int N_ENTRADAS = 6,
    parameter int SEL_WIDTH  = 4
);
    logic [N_ENTRADAS*WIDTH-1:0] entradas;
    logic [SEL_WIDTH-1:0]        seletor;
    logic                        modo;
    logic                        valido_in;
    logic                        pronto_out;
    logic [WIDTH-1:0]            saida;
    logic [SEL_WIDTH-1:0]        canal_out;
    logic                        valido_out;
    logic                        pronto_in;
    logic                        erro_seletor;

    modport master (
        output entradas, seletor, modo, valido_in, pronto_in,
        input  pronto_out, saida, canal_out, valido_out, erro_seletor
    );

    modport slave (
        input  entradas, seletor, modo, valido_in, pronto_in,
        output pronto_out, saida, canal_out, valido_out, erro_seletor
    );
endinterface

// File: rtl/mux_canais_registrado.sv
// N-way registered selector, direct (seletor) or round-robin (internal ptr).
// Latency 1 cycle from accept to saida; one result per cycle at full rate.
// Stalls by dropping pronto_out while a result waits on a low pronto_in.
module mux_canais_registrado #(
    parameter int WIDTH      = 32,
    parameter int N_ENTRADAS = 6,
    parameter int SEL_WIDTH  = 4
) (
    input logic                  clock,
    input logic                  reset,
    mux_canais_registrado_if.slave bus
);
    logic [WIDTH-1:0]     saida_q;
    logic [SEL_WIDTH-1:0] canal_q;
    logic                 valido_q;
    logic                 erro_q;
    logic [SEL_WIDTH-1:0] ptr;

    logic                 pronto;
    logic                 acc;
    logic                 fora_faixa;
    logic [SEL_WIDTH-1:0] indice;
    logic [SEL_WIDTH-1:0] ptr_prox;
    logic [WIDTH-1:0]     dado_sel;

    assign pronto = !valido_q || bus.pronto_in;
    assign acc    = bus.valido_in && pronto;

    // Compare in 32 bits so N_ENTRADAS == 2**SEL_WIDTH does not truncate to zero.
    assign fora_faixa = (32'(bus.seletor) >= N_ENTRADAS);
    assign indice     = bus.modo ? ptr : bus.seletor;
    assign ptr_prox   = (ptr == SEL_WIDTH'(N_ENTRADAS - 1)) ? '0 : ptr + 1'b1;

    // Decoded mux: never forms an out-of-range part-select for a bad seletor.
    always_comb begin
        dado_sel = '0;
        for (int k = 0; k < N_ENTRADAS; k++) begin
            if (indice == SEL_WIDTH'(k)) begin
                dado_sel = bus.entradas[k*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            saida_q  <= '0;
            canal_q  <= '0;
            valido_q <= 1'b0;
            erro_q   <= 1'b0;
            ptr      <= '0;
        end else begin
            erro_q <= 1'b0;
            if (acc) begin
                if (bus.modo) begin
                    saida_q  <= dado_sel;
                    canal_q  <= ptr;
                    valido_q <= 1'b1;
                    ptr      <= ptr_prox;
                end else if (!fora_faixa) begin
                    saida_q  <= dado_sel;
                    canal_q  <= bus.seletor;
                    valido_q <= 1'b1;
                end else begin
                    // Bad request is swallowed; only the old result may drain.
                    erro_q <= 1'b1;
                    if (bus.pronto_in) begin
                        valido_q <= 1'b0;
                    end
                end
            end else if (bus.pronto_in) begin
                valido_q <= 1'b0;
            end
        end
    end

    assign bus.pronto_out   = pronto;
    assign bus.saida        = saida_q;
    assign bus.canal_out    = canal_q;
    assign bus.valido_out   = valido_q;
    assign bus.erro_seletor = erro_q;

    a_ptr_faixa: assert property (@(posedge clock) disable iff (reset)
        32'(ptr) < N_ENTRADAS);

    a_erro_so_direto: assert property (@(posedge clock) disable iff (reset)
        (acc && bus.modo) |=> !bus.erro_seletor);
endmodule

// File: tb/tb_mux_canais_registrado.sv
// Directed bench: default build (32b x 6) and a narrow build (8b x 3, 2-bit selector).
module tb_mux_canais_registrado;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    mux_canais_registrado_if #(.WIDTH(32), .N_ENTRADAS(6), .SEL_WIDTH(4)) ba ();
    mux_canais_registrado_if #(.WIDTH(8),  .N_ENTRADAS(3), .SEL_WIDTH(2)) bb ();

    mux_canais_registrado #(.WIDTH(32), .N_ENTRADAS(6), .SEL_WIDTH(4)) dut_a (
        .clock (clk),
        .reset (rst),
        .bus   (ba)
    );

    mux_canais_registrado #(.WIDTH(8), .N_ENTRADAS(3), .SEL_WIDTH(2)) dut_b (
        .clock (clk),
        .reset (rst),
        .bus   (bb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic ciclo();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulso();
        rst = 1'b1;
        ciclo();
        ciclo();
        rst = 1'b0;
    endtask

    localparam logic [2:0] SCAN_B [5] = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd1};

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        ba.entradas = '0; ba.seletor = '0; ba.modo = 1'b0; ba.valido_in = 1'b0; ba.pronto_in = 1'b0;
        bb.entradas = '0; bb.seletor = '0; bb.modo = 1'b0; bb.valido_in = 1'b0; bb.pronto_in = 1'b0;
        for (int k = 0; k < 6; k++) ba.entradas[k*32 +: 32] = 32'h1000_0000 + 32'(k);
        for (int k = 0; k < 3; k++) bb.entradas[k*8 +: 8] = 8'hA0 + 8'(k);

        // ---------------- reset state (32b x 6) ----------------
        reset_pulso();
        chk("rst_saida", ba.saida, 0);
        chk("rst_canal", ba.canal_out, 0);
        chk("rst_valido", ba.valido_out, 0);
        chk("rst_erro", ba.erro_seletor, 0);
        chk("rst_pronto", ba.pronto_out, 1);

        // ---------------- direct select ----------------
        ba.valido_in = 1'b1; ba.pronto_in = 1'b1; ba.seletor = 4'd3;
        ciclo();
        chk("dir3_saida", ba.saida, 64'h1000_0003);
        chk("dir3_canal", ba.canal_out, 3);
        chk("dir3_valido", ba.valido_out, 1);
        ba.seletor = 4'd0;
        ciclo();
        chk("dir0_saida", ba.saida, 64'h1000_0000);
        chk("dir0_canal", ba.canal_out, 0);
        ba.seletor = 4'd5;
        ciclo();
        chk("dir5_saida", ba.saida, 64'h1000_0005);
        chk("dir5_canal", ba.canal_out, 5);
        chk("dir5_valido", ba.valido_out, 1);

        // ---------------- out of range ----------------
        ba.seletor = 4'd6;
        ciclo();
        chk("oor6_erro", ba.erro_seletor, 1);
        chk("oor6_saida", ba.saida, 64'h1000_0005);
        chk("oor6_canal", ba.canal_out, 5);
        chk("oor6_valido", ba.valido_out, 0);
        ba.seletor = 4'd15;
        ciclo();
        chk("oor15_erro", ba.erro_seletor, 1);
        chk("oor15_saida", ba.saida, 64'h1000_0005);
        chk("oor15_valido", ba.valido_out, 0);
        ba.valido_in = 1'b0;
        ciclo();
        chk("oor_erro_limpo", ba.erro_seletor, 0);

        // ---------------- backpressure ----------------
        ba.valido_in = 1'b1; ba.seletor = 4'd2;
        ciclo();
        chk("bp_aceita2", ba.saida, 64'h1000_0002);
        ba.seletor = 4'd4; ba.pronto_in = 1'b0;
        #1;
        chk("bp_pronto_baixo", ba.pronto_out, 0);
        for (int i = 0; i < 4; i++) begin
            ciclo();
            chk("bp_saida_estavel", ba.saida, 64'h1000_0002);
            chk("bp_canal_estavel", ba.canal_out, 2);
            chk("bp_valido_estavel", ba.valido_out, 1);
            chk("bp_pronto_estavel", ba.pronto_out, 0);
        end
        ba.pronto_in = 1'b1;
        #1;
        chk("bp_pronto_alto", ba.pronto_out, 1);
        ciclo();
        chk("bp_troca_saida", ba.saida, 64'h1000_0004);
        chk("bp_troca_canal", ba.canal_out, 4);
        chk("bp_troca_valido", ba.valido_out, 1);
        ba.valido_in = 1'b0;
        ciclo();
        chk("bp_drena_valido", ba.valido_out, 0);
        chk("bp_drena_saida", ba.saida, 64'h1000_0004);

        // ---------------- scan wrap (ptr still 0) ----------------
        ba.modo = 1'b1; ba.valido_in = 1'b1; ba.seletor = 4'd15;
        for (int i = 0; i < 8; i++) begin
            ciclo();
            chk("scan_canal", ba.canal_out, 64'(i % 6));
            chk("scan_saida", ba.saida, 64'h1000_0000 + 64'(i % 6));
            chk("scan_erro", ba.erro_seletor, 0);
        end

        // ---------------- mode switch ----------------
        ba.valido_in = 1'b0;
        reset_pulso();
        ba.valido_in = 1'b1; ba.modo = 1'b1;
        ciclo();
        chk("ms_canal0", ba.canal_out, 0);
        ciclo();
        chk("ms_canal1", ba.canal_out, 1);
        ba.modo = 1'b0; ba.seletor = 4'd5;
        ciclo();
        chk("ms_canal5", ba.canal_out, 5);
        ba.modo = 1'b1;
        ciclo();
        chk("ms_canal2", ba.canal_out, 2);
        chk("ms_saida2", ba.saida, 64'h1000_0002);

        // ---------------- reset mid-stall (ptr=4) ----------------
        ciclo();
        chk("rs_canal3", ba.canal_out, 3);
        ba.pronto_in = 1'b0;
        ciclo();
        chk("rs_stall_valido", ba.valido_out, 1);
        chk("rs_stall_canal", ba.canal_out, 3);
        rst = 1'b1;
        ciclo();
        rst = 1'b0;
        chk("rs_valido", ba.valido_out, 0);
        chk("rs_saida", ba.saida, 0);
        chk("rs_canal", ba.canal_out, 0);
        ba.pronto_in = 1'b1;
        ciclo();
        chk("rs_scan_canal", ba.canal_out, 0);
        chk("rs_scan_saida", ba.saida, 64'h1000_0000);
        ba.valido_in = 1'b0;
        ciclo();

        // ---------------- narrow build: 8b x 3, 2-bit selector ----------------
        reset_pulso();
        chk("b_rst_saida", bb.saida, 0);
        chk("b_rst_valido", bb.valido_out, 0);
        chk("b_rst_pronto", bb.pronto_out, 1);
        bb.valido_in = 1'b1; bb.pronto_in = 1'b1; bb.seletor = 2'd2;
        ciclo();
        chk("b_dir2_saida", bb.saida, 64'hA2);
        chk("b_dir2_canal", bb.canal_out, 2);
        chk("b_dir2_valido", bb.valido_out, 1);
        bb.seletor = 2'd3;
        ciclo();
        chk("b_oor3_erro", bb.erro_seletor, 1);
        chk("b_oor3_saida", bb.saida, 64'hA2);
        chk("b_oor3_valido", bb.valido_out, 0);

        bb.seletor = 2'd1;
        ciclo();
        chk("b_bp_aceita1", bb.saida, 64'hA1);
        chk("b_bp_erro_limpo", bb.erro_seletor, 0);
        bb.seletor = 2'd2; bb.pronto_in = 1'b0;
        for (int i = 0; i < 2; i++) begin
            ciclo();
            chk("b_bp_saida", bb.saida, 64'hA1);
            chk("b_bp_pronto", bb.pronto_out, 0);
        end
        bb.pronto_in = 1'b1;
        ciclo();
        chk("b_bp_troca", bb.saida, 64'hA2);
        chk("b_bp_troca_valido", bb.valido_out, 1);

        bb.modo = 1'b1; bb.seletor = 2'd3;
        for (int i = 0; i < 5; i++) begin
            ciclo();
            chk("b_scan_canal", bb.canal_out, 64'(SCAN_B[i]));
            chk("b_scan_saida", bb.saida, 64'hA0 + 64'(SCAN_B[i]));
            chk("b_scan_erro", bb.erro_seletor, 0);
        end
        bb.valido_in = 1'b0;
        ciclo();
        chk("b_drena_valido", bb.valido_out, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
